// File: rtl/riscv_pipe_pkg.sv
// Shared MEM/WB definitions: destination width, payload field layout and the
// skid-stage occupancy encoding, so MEM packs and WB unpacks identically.
package riscv_pipe_pkg;

    localparam int unsigned RD_W       = 5;
    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned ALU_O_W    = 32;
    localparam int unsigned CSR_ADDR_W = 12;
    localparam int unsigned CSR_DATA_W = 32;
    localparam int unsigned RSVD_W     = 14;

    // Field LSB offsets inside the flat payload vector (wr_csr at bit 0)
    localparam int unsigned WR_CSR_LSB    = 0;
    localparam int unsigned MEM2REG_LSB   = 1;
    localparam int unsigned MEM_DATA_LSB  = 2;
    localparam int unsigned ALU_O_LSB     = MEM_DATA_LSB + MEM_DATA_W;
    localparam int unsigned CSR_WADDR_LSB = ALU_O_LSB + ALU_O_W;
    localparam int unsigned CSR_WDATA_LSB = CSR_WADDR_LSB + CSR_ADDR_W;
    localparam int unsigned CSR_RADDR_LSB = CSR_WDATA_LSB + CSR_DATA_W;
    localparam int unsigned RSVD_LSB      = CSR_RADDR_LSB + CSR_ADDR_W;

    typedef struct packed {
        logic [RSVD_W-1:0]     rsvd;
        logic [CSR_ADDR_W-1:0] csr_raddr;
        logic [CSR_DATA_W-1:0] csr_wdata;
        logic [CSR_ADDR_W-1:0] csr_waddr;
        logic [ALU_O_W-1:0]    alu_o;
        logic [MEM_DATA_W-1:0] mem_data;
        logic                  mem2reg;
        logic                  wr_csr;
    } mem_wb_payload_t;

    localparam int unsigned MEM_WB_PAYLOAD_W = $bits(mem_wb_payload_t);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_HEAD  = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_t;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB stage register with a 2-entry skid buffer; in_ready is a flop so
// WB backpressure never reaches MEM combinationally.
module mem_wb_skid_stage
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = riscv_pipe_pkg::MEM_WB_PAYLOAD_W,
    parameter int unsigned RD_W      = riscv_pipe_pkg::RD_W,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [RD_W-1:0]      in_rd,
    input  logic                 in_regs_write,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [RD_W-1:0]      out_rd,
    output logic                 out_regs_write,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    occ_state_t           state, state_nx;
    logic                 in_ready_q;
    logic [PAYLOAD_W-1:0] head_payload, skid_payload;
    logic [RD_W-1:0]      head_rd, skid_rd;
    logic                 head_rw, skid_rw;
    logic                 acc, pop, stall, kill;
    logic                 load_head_in, load_head_skid, load_skid;
    logic                 clr_head, clr_skid;

    assign out_valid = (state != OCC_EMPTY);
    assign acc       = in_valid & in_ready_q;
    assign pop       = out_valid & out_ready;
    assign stall     = out_valid & ~out_ready;
    assign kill      = flush & out_valid;

    always_comb begin
        state_nx       = state;
        load_head_in   = 1'b0;
        load_head_skid = 1'b0;
        load_skid      = 1'b0;
        clr_head       = 1'b0;
        clr_skid       = 1'b0;
        if (flush) begin
            state_nx = OCC_EMPTY;
            clr_head = 1'b1;
            clr_skid = 1'b1;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (acc) begin
                        state_nx     = OCC_HEAD;
                        load_head_in = 1'b1;
                    end
                end
                OCC_HEAD: begin
                    if (pop && acc) begin
                        load_head_in = 1'b1;
                    end else if (acc) begin
                        state_nx  = OCC_FULL;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_nx = OCC_EMPTY;
                        clr_head = 1'b1;
                    end
                end
                // in_ready is low here, so no accept can coincide with the pop
                OCC_FULL: begin
                    if (pop) begin
                        state_nx       = OCC_HEAD;
                        load_head_skid = 1'b1;
                        clr_skid       = 1'b1;
                    end
                end
                default: begin
                    state_nx = OCC_EMPTY;
                    clr_head = 1'b1;
                    clr_skid = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= OCC_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nx;
            in_ready_q <= (state_nx != OCC_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_payload <= '0;
            head_rd      <= '0;
            head_rw      <= 1'b0;
        end else if (clr_head) begin
            head_payload <= '0;
            head_rd      <= '0;
            head_rw      <= 1'b0;
        end else if (load_head_in) begin
            head_payload <= in_payload;
            head_rd      <= in_rd;
            head_rw      <= in_regs_write;
        end else if (load_head_skid) begin
            head_payload <= skid_payload;
            head_rd      <= skid_rd;
            head_rw      <= skid_rw;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_payload <= '0;
            skid_rd      <= '0;
            skid_rw      <= 1'b0;
        end else if (clr_skid) begin
            skid_payload <= '0;
            skid_rd      <= '0;
            skid_rw      <= 1'b0;
        end else if (load_skid) begin
            skid_payload <= in_payload;
            skid_rd      <= in_rd;
            skid_rw      <= in_regs_write;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_payload    = head_payload;
    assign out_rd         = head_rd;
    assign out_regs_write = head_rw & out_valid;
    assign occupancy      = state;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (kill),
        .count (flush_cnt)
    );

endmodule
